mac_ctrl: RTL and testbench

MAC_CTRL -- requirements
Module: mac_ctrl

---
 rtl/mac_ctrl.sv | 106 ++++++++++
 tb/tb_mac_ctrl.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/mac_ctrl.sv
// MAC sequencing controller: clears the accumulator and counter, then accepts num_terms operand pairs and pulses done.
// Optional abort input enabled by defining MAC_CTRL_ABORT_EN.
module mac_ctrl #(
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] num_terms,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [CNT_W-1:0] count_out,
`ifdef MAC_CTRL_ABORT_EN
  input  logic             abort,
`endif
  output logic             count_enb,
  output logic             count_reset,
  output logic             acc_clr,
  output logic             acc_en,
  output logic             busy,
  output logic             done
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_CLEAR = 2'd1;
  localparam logic [1:0] S_RUN   = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]       r_state;
  logic [1:0]       w_state_nxt;
  logic [CNT_W-1:0] r_term;
  logic             w_abort;

`ifdef MAC_CTRL_ABORT_EN
  assign w_abort = abort;
`else
  assign w_abort = 1'b0;
`endif

  // State and captured term count
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_term  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == S_IDLE && start) begin
        r_term <= num_terms;
      end
    end
  end

  // Next state and outputs, decoded from the reset-cleared state register
  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    acc_en      = 1'b0;
    count_enb   = 1'b0;
    count_reset = 1'b0;
    acc_clr     = 1'b0;
    done        = 1'b0;
    busy        = (r_state != S_IDLE);
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = S_CLEAR;
        end
      end
      S_CLEAR: begin
        acc_clr     = 1'b1;
        count_reset = 1'b1;
        if (w_abort) begin
          w_state_nxt = S_IDLE;
        end else if (r_term != '0) begin
          w_state_nxt = S_RUN;
        end else begin
          w_state_nxt = S_DONE;
        end
      end
      S_RUN: begin
        // An aborted cycle must not look like an accepted handshake upstream
        if (w_abort) begin
          count_reset = 1'b1;
          w_state_nxt = S_IDLE;
        end else begin
          in_ready = 1'b1;
          if (in_valid) begin
            acc_en    = 1'b1;
            count_enb = 1'b1;
            if (count_out == r_term - CNT_W'(1)) begin
              w_state_nxt = S_DONE;
            end
          end
        end
      end
      S_DONE: begin
        done        = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_mac_ctrl.sv
// Self-checking bench for mac_ctrl: vector table, directed corner sequences and randomized runs against a trace model.
module tb_mac_ctrl;

  localparam int unsigned CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [CNT_W-1:0] num_terms;
  logic             in_valid;
  logic             in_ready;
  logic [CNT_W-1:0] count_out;
  logic             count_enb;
  logic             count_reset;
  logic             acc_clr;
  logic             acc_en;
  logic             busy;
  logic             done;
`ifdef MAC_CTRL_ABORT_EN
  logic             abort;
`endif

  int n_chk  = 0;
  int n_fail = 0;
  int done_seen = 0;

  mac_ctrl #(.CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .num_terms  (num_terms),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .count_out  (count_out),
`ifdef MAC_CTRL_ABORT_EN
    .abort      (abort),
`endif
    .count_enb  (count_enb),
    .count_reset(count_reset),
    .acc_clr    (acc_clr),
    .acc_en     (acc_en),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  // Downstream term counter driven by the controller
  always @(posedge clk or posedge rst) begin
    if (rst) count_out <= '0;
    else if (count_reset) count_out <= '0;
    else if (count_enb) count_out <= count_out + CNT_W'(1);
  end

  always @(posedge clk) if (!rst && done) done_seen <= done_seen + 1;

  // {busy, in_ready, acc_en, count_enb, acc_clr, count_reset, done}
  function automatic logic [6:0] outs();
    return {busy, in_ready, acc_en, count_enb, acc_clr, count_reset, done};
  endfunction

  task automatic chk(input string nm, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      n_chk++;
      if (count_enb && count_reset) begin
        n_fail++;
        $display("FAIL enb_and_reset: both asserted at %0t", $time);
      end
    end
  end

  // Expected trace follows from the N-th valid beat: clear, run until that beat, done, idle
  task automatic run_seq(input int n, input int mode, input string nm);
    bit vld[64];
    int k;
    int seen;
    logic [6:0] e;
    k = 0;
    seen = 0;
    for (int i = 0; i < 64; i++) begin
      if (mode == 0) vld[i] = 1'b1;
      else if (mode == 1) vld[i] = (i % 2 == 0);
      else vld[i] = (($urandom % 2) == 1) || (i >= 40);
    end
    for (int i = 0; i < 64; i++) begin
      if (seen < n && vld[i]) begin
        seen++;
        if (seen == n) k = i + 1;
      end
    end
    @(negedge clk);
    start = 1'b1;
    num_terms = CNT_W'(n);
    in_valid = 1'($urandom);
    #1 chk({nm, "_idle0"}, int'(outs()), 0);
    for (int t = 0; t <= k + 1; t++) begin
      @(negedge clk);
      start = 1'($urandom);
      num_terms = CNT_W'($urandom);
      in_valid = (t >= 1 && t <= k) ? vld[t-1] : 1'($urandom);
      #1;
      if (t == 0) e = 7'b1000110;
      else if (t <= k) e = {1'b1, 1'b1, vld[t-1], vld[t-1], 3'b000};
      else e = 7'b1000001;
      chk($sformatf("%s_t%0d", nm, t), int'(outs()), int'(e));
      if (t == k + 1) chk({nm, "_count"}, int'(count_out), n);
    end
    @(negedge clk);
    start = 1'b0;
    in_valid = 1'b0;
    #1 chk({nm, "_idle1"}, int'(outs()), 0);
  endtask

  typedef struct {
    logic             start;
    logic [CNT_W-1:0] nt;
    logic             vld;
    logic [6:0]       exp;
  } vec_t;

  vec_t vt[11];
  int d0;

  initial begin
    // N=3 held valid, start ignored in DONE, then N=0
    vt[0]  = '{1'b1, 4'd3, 1'b1, 7'b0000000};
    vt[1]  = '{1'b0, 4'd9, 1'b1, 7'b1000110};
    vt[2]  = '{1'b0, 4'd9, 1'b1, 7'b1111000};
    vt[3]  = '{1'b0, 4'd9, 1'b1, 7'b1111000};
    vt[4]  = '{1'b0, 4'd9, 1'b1, 7'b1111000};
    vt[5]  = '{1'b1, 4'd2, 1'b1, 7'b1000001};
    vt[6]  = '{1'b0, 4'd0, 1'b0, 7'b0000000};
    vt[7]  = '{1'b1, 4'd0, 1'b1, 7'b0000000};
    vt[8]  = '{1'b0, 4'd5, 1'b1, 7'b1000110};
    vt[9]  = '{1'b0, 4'd5, 1'b1, 7'b1000001};
    vt[10] = '{1'b0, 4'd0, 1'b1, 7'b0000000};

    rst = 1'b1;
    start = 1'b0;
    num_terms = '0;
    in_valid = 1'b1;
`ifdef MAC_CTRL_ABORT_EN
    abort = 1'b0;
`endif
    #2 chk("reset_outs", int'(outs()), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      start = vt[i].start;
      num_terms = vt[i].nt;
      in_valid = vt[i].vld;
      #1 chk($sformatf("vec%0d", i), int'(outs()), int'(vt[i].exp));
    end

    run_seq(4, 1, "toggle4");
    run_seq(15, 0, "full15");
    run_seq(0, 2, "zero");

    // Asynchronous reset in RUN after two transfers
    @(negedge clk); start = 1'b1; num_terms = 4'd5; in_valid = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    #1 chk("pre_rst_run", int'(outs()), 7'b1111000);
    chk("pre_rst_count", int'(count_out), 2);
    d0 = done_seen;
    rst = 1'b1;
    #1 chk("rst_async", int'(outs()), 0);
    @(negedge clk);
    rst = 1'b0;
    #1 chk("rst_release", int'(outs()), 0);
    @(negedge clk);
    #1 chk("rst_idle", int'(outs()), 0);
    chk("rst_no_done", done_seen, d0);
    run_seq(2, 0, "after_rst");

`ifdef MAC_CTRL_ABORT_EN
    @(negedge clk); start = 1'b1; num_terms = 4'd5; in_valid = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    d0 = done_seen;
    @(negedge clk); abort = 1'b1;
    #1 chk("abort_ctl", int'({count_reset, acc_en, count_enb}), 3'b100);
    @(negedge clk); abort = 1'b0;
    #1 chk("abort_idle", int'(outs()), 0);
    chk("abort_no_done", done_seen, d0);
    run_seq(3, 2, "after_abort");
`endif

    for (int r = 0; r < 20; r++) begin
      run_seq(int'($urandom_range(0, 15)), 2, $sformatf("rnd%0d", r));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
